multi_load_divider: RTL

- Parametrised, multi-channel successor to the single-channel loadable fractional divider.
- Each channel is a WIDTH-bit phase accumulator with its own increment, enable and phase clear.
- Increments load either immediately or deferred to the channel's next wrap, so retuning is glitch-free.
- Sits between the system clock and the clock/display timing logic; one channel per derived rate (e.g. 1 Hz tick, display refresh).

---
 rtl/multi_load_divider_pkg.sv | 32 +++
 rtl/multi_load_divider_channel.sv | 104 ++++++++++
 rtl/multi_load_divider.sv | 58 +++++
 3 files changed

// File: rtl/multi_load_divider_pkg.sv
// Shared constants, state type and increment helper for the multi-channel
// loadable fractional divider.
package multi_load_divider_pkg;

    // Values of i_load_defer
    localparam logic LOAD_NOW   = 1'b0;
    localparam logic LOAD_DEFER = 1'b1;

    // Increment held by every channel (active and shadow) out of reset
    localparam int INCR_RESET = 1;

    // Per-channel deferred-load tracking
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } load_state_t;

    // Effective increment = requested + 1, saturating at all-ones so that an
    // all-ones request never wraps to a zero (stalled) increment.
    // Works on up to 64-bit fields; callers truncate to their own width.
    function automatic logic [63:0] clamp_incr(input logic [63:0] req, input int width);
        logic [63:0] mask;
        logic [63:0] req_m;
        mask  = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        req_m = req & mask;
        if (req_m == mask) begin
            return mask;
        end
        return req_m + 64'd1;
    endfunction

endpackage

// File: rtl/multi_load_divider_channel.sv
// One divider channel: phase accumulator, active and shadow increments,
// deferred-load state and the registered overflow pulse.
module load_divider_channel
    import multi_load_divider_pkg::*;
#(
    parameter int WIDTH = 25
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_load_now,
    input  logic             i_load_defer,
    input  logic [WIDTH-1:0] i_incr_eff,
    input  logic             i_phase_clr,
    output logic             o_div,
    output logic             o_clk_overflow,
    output logic             o_load_pending
);

    localparam logic [WIDTH-1:0] INCR_INIT = WIDTH'(INCR_RESET);

    load_state_t      state_reg,  state_next;
    logic [WIDTH-1:0] acc_reg,    acc_next;
    logic [WIDTH-1:0] incr_reg,   incr_next;
    logic [WIDTH-1:0] shadow_reg, shadow_next;
    logic             ovf_reg,    ovf_next;
    logic [WIDTH:0]   sum;
    logic             carry;

    // Add one bit wider than the accumulator so the top bit is the wrap carry
    always_comb begin
        sum   = {1'b0, acc_reg} + {1'b0, incr_reg};
        carry = i_en & sum[WIDTH] & ~i_phase_clr;
    end

    // Next-state: accumulator advance/clear and the deferred-load machine
    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        incr_next   = incr_reg;
        shadow_next = shadow_reg;
        ovf_next    = 1'b0;

        // Clear overrides enable; a disabled channel holds and drops the pulse
        if (i_phase_clr) begin
            acc_next = '0;
        end else if (i_en) begin
            acc_next = sum[WIDTH-1:0];
            ovf_next = sum[WIDTH];
        end

        case (state_reg)
            ST_IDLE: begin
                if (i_load_defer) begin
                    shadow_next = i_incr_eff;
                    state_next  = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // Wrap or clear hands over the shadow that was already waiting
                if (carry || i_phase_clr) begin
                    incr_next  = shadow_reg;
                    state_next = ST_IDLE;
                end
                // A new deferred load always lands in shadow for the next wrap
                if (i_load_defer) begin
                    shadow_next = i_incr_eff;
                    state_next  = ST_PENDING;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Immediate load wins over any transfer and cancels a waiting one
        if (i_load_now) begin
            incr_next  = i_incr_eff;
            state_next = ST_IDLE;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            incr_reg   <= INCR_INIT;
            shadow_reg <= INCR_INIT;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            incr_reg   <= incr_next;
            shadow_reg <= shadow_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign o_div          = acc_reg[WIDTH-1];
    assign o_clk_overflow = ovf_reg;
    assign o_load_pending = (state_reg == ST_PENDING);

endmodule

// File: rtl/multi_load_divider.sv
// Multi-channel loadable fractional clock divider: decodes the shared load
// port into per-channel strobes and replicates the channel logic.
module multi_load_divider
    import multi_load_divider_pkg::*;
#(
    parameter int WIDTH    = 25,
    parameter int CHANNELS = 2,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [CHANNELS-1:0] i_en,
    input  logic                i_load,
    input  logic [CH_W-1:0]     i_load_chan,
    input  logic                i_load_defer,
    input  logic [WIDTH-1:0]    i_incriment,
    input  logic [CHANNELS-1:0] i_phase_clr,
    output logic [CHANNELS-1:0] o_div,
    output logic [CHANNELS-1:0] o_clk_overflow,
    output logic [CHANNELS-1:0] o_load_pending
);

    logic [WIDTH-1:0]    incr_eff;
    logic [CHANNELS-1:0] load_now;
    logic [CHANNELS-1:0] load_defer;

    // One shared clamp; every channel sees the same effective increment
    always_comb begin
        incr_eff = WIDTH'(clamp_incr(64'(i_incriment), WIDTH));
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            // Out-of-range channel numbers match no channel and are dropped
            always_comb begin
                load_now[gi]   = i_load && (i_load_chan == CH_W'(gi)) && (i_load_defer == LOAD_NOW);
                load_defer[gi] = i_load && (i_load_chan == CH_W'(gi)) && (i_load_defer == LOAD_DEFER);
            end

            load_divider_channel #(
                .WIDTH (WIDTH)
            ) u_chan (
                .i_clk          (i_clk),
                .i_reset        (i_reset),
                .i_en           (i_en[gi]),
                .i_load_now     (load_now[gi]),
                .i_load_defer   (load_defer[gi]),
                .i_incr_eff     (incr_eff),
                .i_phase_clr    (i_phase_clr[gi]),
                .o_div          (o_div[gi]),
                .o_clk_overflow (o_clk_overflow[gi]),
                .o_load_pending (o_load_pending[gi])
            );
        end
    endgenerate

endmodule
